// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic block set: default operand width and
// the divider control-state encoding.
package arith_pkg;

    localparam int ARITH_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } div_state_e;

endpackage

// File: rtl/addsub_nbit.sv
// N-bit ripple-carry adder/subtractor: sub_i=1 inverts b and injects a carry-in,
// so cout_o=1 on a subtraction means "no borrow" (a >= b).
module addsub_nbit
    import arith_pkg::*;
#(
    parameter int N = ARITH_WIDTH + 1
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         sub_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic [N-1:0] b_x_s;
    logic [N:0]   carry_s;

    // Ripple chain of full adders over the conditionally complemented operand.
    always_comb begin
        b_x_s      = b_i ^ {N{sub_i}};
        carry_s    = '0;
        sum_o      = '0;
        carry_s[0] = sub_i;
        for (int i = 0; i < N; i++) begin
            sum_o[i]       = a_i[i] ^ b_x_s[i] ^ carry_s[i];
            carry_s[i + 1] = (a_i[i] & b_x_s[i]) | (carry_s[i] & (a_i[i] ^ b_x_s[i]));
        end
        cout_o = carry_s[N];
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock with a
// start/done handshake; divide-by-zero finishes in a single cycle.
module seq_restoring_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] prem_q,  prem_d;
    logic [WIDTH-1:0] qsh_q,   qsh_d;
    logic [WIDTH-1:0] dvs_q,   dvs_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [WIDTH-1:0] quot_q,  quot_d;
    logic [WIDTH-1:0] rem_q,   rem_d;
    logic             dbz_q,   dbz_d;

    logic [WIDTH:0]   trial_a_s;
    logic [WIDTH:0]   trial_b_s;
    logic [WIDTH:0]   diff_s;
    logic             no_borrow_s;
    logic [WIDTH-1:0] step_rem_s;
    logic [WIDTH-1:0] step_q_s;
    logic             unused_s;

    assign trial_a_s = {prem_q, qsh_q[WIDTH-1]};
    assign trial_b_s = {1'b0, dvs_q};

    addsub_nbit #(
        .N (WIDTH + 1)
    ) u_trial_sub (
        .a_i    (trial_a_s),
        .b_i    (trial_b_s),
        .sub_i  (1'b1),
        .sum_o  (diff_s),
        .cout_o (no_borrow_s)
    );

    // When the trial subtraction fits, the top bits are zero by construction.
    assign unused_s = diff_s[WIDTH] ^ trial_a_s[WIDTH];

    // One restoring step: keep the difference or restore the shifted remainder.
    always_comb begin
        step_q_s = {qsh_q[WIDTH-2:0], no_borrow_s};
        if (no_borrow_s) begin
            step_rem_s = diff_s[WIDTH-1:0];
        end else begin
            step_rem_s = trial_a_s[WIDTH-1:0];
        end
    end

    // Control FSM next-state and registered-output next values.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        prem_d  = prem_q;
        qsh_d   = qsh_q;
        dvs_d   = dvs_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                if (start) begin
                    if (divisor != '0) begin
                        state_d = S_CALC;
                        count_d = CNT_LOAD;
                        prem_d  = '0;
                        qsh_d   = dividend;
                        dvs_d   = divisor;
                        busy_d  = 1'b1;
                        dbz_d   = 1'b0;
                    end else begin
                        state_d = S_FIN;
                        count_d = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        dbz_d   = 1'b1;
                        quot_d  = '1;
                        rem_d   = dividend;
                    end
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_CALC: begin
                prem_d  = step_rem_s;
                qsh_d   = step_q_s;
                count_d = count_q - CNT_ONE;
                if (count_q == CNT_ONE) begin
                    state_d = S_FIN;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    quot_d  = step_q_s;
                    rem_d   = step_rem_s;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any division in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            prem_q  <= '0;
            qsh_q   <= '0;
            dvs_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            prem_q  <= prem_d;
            qsh_q   <= qsh_d;
            dvs_q   <= dvs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench: a cycle-level scoreboard built on plain '/' and '%'
// is compared every cycle, plus directed vectors with literal expectations.
module tb_seq_restoring_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_left = 0;
    int m_done = 0;
    int m_q    = 0;
    int m_r    = 0;
    int m_dbz  = 0;
    int pend_q = 0;
    int pend_r = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Behavioural model: busy for W cycles after acceptance, then a done pulse.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 0;
            m_q    <= 0;
            m_r    <= 0;
            m_dbz  <= 0;
        end else begin
            m_done <= 0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1;
                    m_q    <= pend_q;
                    m_r    <= pend_r;
                end
            end else if (start === 1'b1) begin
                if (divisor == 0) begin
                    m_done <= 1;
                    m_dbz  <= 1;
                    m_q    <= 15;
                    m_r    <= int'(dividend);
                end else begin
                    m_left <= W;
                    m_dbz  <= 0;
                    pend_q <= int'(dividend) / int'(divisor);
                    pend_r <= int'(dividend) % int'(divisor);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Returns edges since acceptance (accepting edge counts as 1) and busy cycles seen.
    task automatic wait_done(output int lat, output int busy_n);
        lat    = 1;
        busy_n = 0;
        while (done !== 1'b1 && lat < 12) begin
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
            lat++;
        end
        chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic chk_result(input string tag, input int q, input int r, input int dz);
        chk({tag, "_quotient"}, {28'd0, quotient}, q);
        chk({tag, "_remainder"}, {28'd0, remainder}, r);
        chk({tag, "_dbz"}, {31'd0, div_by_zero}, dz);
    endtask

    initial begin
        int lat;
        int bn;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;

        fork
            forever begin
                @(negedge clk);
                chk("cmp_busy", {31'd0, busy}, (m_left > 0) ? 32'd1 : 32'd0);
                chk("cmp_done", {31'd0, done}, m_done);
                chk("cmp_quotient", {28'd0, quotient}, m_q);
                chk("cmp_remainder", {28'd0, remainder}, m_r);
                chk("cmp_dbz", {31'd0, div_by_zero}, m_dbz);
            end
        join_none

        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk_result("rst", 0, 0, 0);
        rst = 1'b0;

        start_div(4'd13, 4'd3);
        wait_done(lat, bn);
        chk("lat_13_3", lat, 32'd5);
        chk("busy_cycles_13_3", bn, 32'd4);
        chk_result("d13_3", 4, 1, 0);
        @(negedge clk);
        chk("done_single_pulse", {31'd0, done}, 32'd0);

        start_div(4'd15, 4'd1);
        wait_done(lat, bn);
        chk_result("d15_1", 15, 0, 0);

        start_div(4'd7, 4'd9);
        wait_done(lat, bn);
        chk_result("d7_9", 0, 7, 0);

        start_div(4'd9, 4'd0);
        wait_done(lat, bn);
        chk("lat_div0", lat, 32'd1);
        chk("busy_cycles_div0", bn, 32'd0);
        chk_result("d9_0", 15, 9, 1);

        start_div(4'd12, 4'd5);
        @(negedge clk);
        start    = 1'b1;
        dividend = 4'd15;
        divisor  = 4'd15;
        @(negedge clk);
        start    = 1'b0;
        wait_done(lat, bn);
        chk("lat_ignored_start", lat, 32'd3);
        chk_result("d12_5", 2, 2, 0);

        // Back-to-back: request while done is high.
        start    = 1'b1;
        dividend = 4'd15;
        divisor  = 4'd15;
        @(negedge clk);
        start    = 1'b0;
        wait_done(lat, bn);
        chk("lat_back_to_back", lat, 32'd5);
        chk_result("d15_15", 1, 0, 0);

        start_div(4'd14, 4'd3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk_result("arst", 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("no_done_after_abort", {31'd0, done}, 32'd0);
        end
        start_div(4'd14, 4'd3);
        wait_done(lat, bn);
        chk("lat_14_3", lat, 32'd5);
        chk_result("d14_3", 4, 2, 0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                start_div(4'(a), 4'(b));
                wait_done(lat, bn);
                if (b != 0) begin
                    chk("sweep_invariant", int'(quotient) * b + int'(remainder), a);
                    chk("sweep_rem_lt_div", (int'(remainder) < b) ? 32'd1 : 32'd0, 32'd1);
                    chk("sweep_dbz_clear", {31'd0, div_by_zero}, 32'd0);
                end else begin
                    chk_result("sweep_div0", 15, a, 1);
                end
            end
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
